// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes and funct fields.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_ILL = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 -> operation for the base (funct7 = 0) encoding; SLTU/SLTIU unsupported
    function automatic alu_ctrl_e base_ctrl(input logic [2:0] funct3);
        case (funct3)
            F3_ADD_SUB: return ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return ALU_SRL;
            F3_OR:      return ALU_OR;
            F3_AND:     return ALU_AND;
            default:    return ALU_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU operands and control.
module alu_decode
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      ctrl,
    output logic [4:0]      rd,
    output logic            wen,
    output logic            illegal
);

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    alu_ctrl_e       ctrl_d;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

    // Any path that does not pick a code leaves ALU_ILL, which marks the instruction illegal
    always_comb begin
        ctrl_d = ALU_ILL;
        a_d    = '0;
        b_d    = '0;
        case (instr[6:0])
            OPC_OP: begin
                a_d = rs1;
                b_d = rs2;
                if (funct7 == F7_BASE) begin
                    ctrl_d = base_ctrl(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB)      ctrl_d = ALU_SUB;
                    else if (funct3 == F3_SRL_SRA) ctrl_d = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                a_d = rs1;
                b_d = imm_i;
                if (funct3 == F3_SLL) begin
                    b_d = shamt;
                    if (funct7 == F7_BASE) ctrl_d = ALU_SLL;
                end else if (funct3 == F3_SRL_SRA) begin
                    b_d = shamt;
                    if (funct7 == F7_BASE)     ctrl_d = ALU_SRL;
                    else if (funct7 == F7_ALT) ctrl_d = ALU_SRA;
                end else begin
                    ctrl_d = base_ctrl(funct3);
                end
            end
            OPC_LUI: begin
                b_d    = imm_u;
                ctrl_d = ALU_ADD;
            end
            OPC_AUIPC: begin
                a_d    = pc;
                b_d    = imm_u;
                ctrl_d = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign illegal = (ctrl_d == ALU_ILL);
    assign ctrl    = ctrl_d;
    assign a       = illegal ? '0 : a_d;
    assign b       = illegal ? '0 : b_d;
    assign rd      = instr[11:7];
    assign wen     = !illegal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// One-entry ID/EX register with valid/ready handshake around alu_decode.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [3:0]      dec_ctrl;
    logic [4:0]      dec_rd;
    logic            dec_wen;
    logic            dec_illegal;
    logic            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    alu_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .pc      (in_pc),
        .rs1     (in_rs1_data),
        .rs2     (in_rs2_data),
        .a       (dec_a),
        .b       (dec_b),
        .ctrl    (dec_ctrl),
        .rd      (dec_rd),
        .wen     (dec_wen),
        .illegal (dec_illegal)
    );

    // Entry occupancy: flush wins, then a new acceptance, then consumption
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on acceptance, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a        <= '0;
            out_b        <= '0;
            out_alu_ctrl <= '0;
            out_rd       <= '0;
            out_wen      <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            out_a        <= dec_a;
            out_b        <= dec_b;
            out_alu_ctrl <= dec_ctrl;
            out_rd       <= dec_rd;
            out_wen      <= dec_wen;
            out_illegal  <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: reference decode model plus directed and random traffic.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    logic exp_valid = 1'b0;
    exp_t exp_e;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_wen      (out_wen),
        .out_illegal  (out_illegal)
    );

    // ALU code for funct3 in the base encoding, -1 when unsupported
    function automatic int r_code(input logic [2:0] f3);
        case (f3)
            3'd0: return 0;
            3'd1: return 5;
            3'd2: return 8;
            3'd4: return 4;
            3'd5: return 6;
            3'd6: return 3;
            3'd7: return 2;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int code;
        int simm;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] opa;
        logic [31:0] opb;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        code = -1;
        opa = 32'd0;
        opb = 32'd0;
        if (op == 7'h33) begin
            opa = r1;
            opb = r2;
            if (f7 == 7'h00) code = r_code(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
        end else if (op == 7'h13) begin
            opa = r1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                opb = 32'(ins[24:20]);
                if (f7 == 7'h00) code = (f3 == 3'd1) ? 5 : 6;
                else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
            end else begin
                simm = int'(ins[31:20]);
                if (simm >= 2048) simm = simm - 4096;
                opb = 32'(simm);
                code = r_code(f3);
            end
        end else if (op == 7'h37) begin
            opb = ins & 32'hFFFF_F000;
            code = 0;
        end else if (op == 7'h17) begin
            opa = pc;
            opb = ins & 32'hFFFF_F000;
            code = 0;
        end
        e.rd = ins[11:7];
        if (code < 0) begin
            e.a = 32'd0; e.b = 32'd0; e.ctrl = 4'hF; e.wen = 1'b0; e.ill = 1'b1;
        end else begin
            e.a = opa; e.b = opb; e.ctrl = 4'(code); e.wen = (e.rd != 5'd0); e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                                input logic [4:0] rd, input logic wen, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = ctrl; e.rd = rd; e.wen = wen; e.ill = ill;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".a"}, out_a, e.a);
        check({tag, ".b"}, out_b, e.b);
        check({tag, ".ctrl"}, 32'(out_alu_ctrl), 32'(e.ctrl));
        check({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
        check({tag, ".wen"}, 32'(out_wen), 32'(e.wen));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
    endtask

    task automatic check_model(input string tag, input exp_t got, input exp_t want);
        check({tag, ".a"}, got.a, want.a);
        check({tag, ".b"}, got.b, want.b);
        check({tag, ".ctrl"}, 32'(got.ctrl), 32'(want.ctrl));
        check({tag, ".wen"}, 32'(got.wen), 32'(want.wen));
        check({tag, ".ill"}, 32'(got.ill), 32'(want.ill));
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h13;
            default: ;
        endcase
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // Reference: the entry is occupied after an accepted offer, empty after consumption or flush
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_valid = 1'b0;
        end else begin
            if (flush) begin
                exp_valid = 1'b0;
            end else if (in_valid && (!exp_valid || out_ready)) begin
                exp_valid = 1'b1;
                exp_e = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    // Compare DUT against the reference on every falling edge
    always @(negedge clk) begin
        check("no_x", 32'($isunknown({out_valid, in_ready, out_a, out_b, out_alu_ctrl,
                                      out_rd, out_wen, out_illegal})), 32'd0);
        if (!rst_n) begin
            check("rst.out_valid", 32'(out_valid), 32'd0);
            check("rst.in_ready", 32'(in_ready), 32'd1);
        end else begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
            if (exp_valid) check_out("model", exp_e);
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc = 32'd0;
        in_rs1_data = 32'd0;
        in_rs2_data = 32'd0;
        flush = 1'b0;
        out_ready = 1'b0;

        // Pin the reference model against hand-decoded instructions
        check_model("pin_add", ref_decode(32'h002081B3, 32'd0, 32'd10, 32'd5), mk(32'd10, 32'd5, 4'h0, 5'd3, 1'b1, 1'b0));
        check_model("pin_srai", ref_decode(32'h40235293, 32'd0, 32'hFFFF_FFF0, 32'd0), mk(32'hFFFF_FFF0, 32'd2, 4'h7, 5'd5, 1'b1, 1'b0));
        check_model("pin_addi_neg", ref_decode(32'hFFF08093, 32'd0, 32'd4, 32'd0), mk(32'd4, 32'hFFFF_FFFF, 4'h0, 5'd1, 1'b1, 1'b0));
        check_model("pin_sltu", ref_decode(32'h0020B1B3, 32'd0, 32'd1, 32'd2), mk(32'd0, 32'd0, 4'hF, 5'd3, 1'b0, 1'b1));

        // Reset state while rst_n is held low
        #2;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check_out("reset", mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back directed instructions, one per cycle
        out_ready = 1'b1;
        offer(32'h002081B3, 32'h0, 32'd10, 32'd5);               // add x3,x1,x2
        @(posedge clk); #1;
        check("add.valid", 32'(out_valid), 32'd1);
        check_out("add", mk(32'd10, 32'd5, 4'h0, 5'd3, 1'b1, 1'b0));
        offer(32'h40235293, 32'h0, 32'hFFFF_FFF0, 32'd7);        // srai x5,x6,2
        @(posedge clk); #1;
        check_out("srai", mk(32'hFFFF_FFF0, 32'd2, 4'h7, 5'd5, 1'b1, 1'b0));
        offer(32'h40231293, 32'h0, 32'd3, 32'd7);                // slli with funct7 0100000
        @(posedge clk); #1;
        check_out("slli_bad", mk(32'd0, 32'd0, 4'hF, 5'd5, 1'b0, 1'b1));
        offer(32'h12345097, 32'h100, 32'd9, 32'd9);              // auipc x1,0x12345
        @(posedge clk); #1;
        check_out("auipc", mk(32'h100, 32'h1234_5000, 4'h0, 5'd1, 1'b1, 1'b0));
        offer(32'h00513093, 32'h0, 32'd9, 32'd9);                // sltiu x1,x2,5
        @(posedge clk); #1;
        check_out("sltiu", mk(32'd0, 32'd0, 4'hF, 5'd1, 1'b0, 1'b1));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.valid", 32'(out_valid), 32'd0);

        // Stall: held entry stays stable, offered instruction waits
        out_ready = 1'b0;
        offer(32'h002081B3, 32'h0, 32'd111, 32'd1);
        @(posedge clk); #1;
        check("stall.first_a", out_a, 32'd111);
        offer(32'h002081B3, 32'h0, 32'd222, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall.in_ready", 32'(in_ready), 32'd0);
            check("stall.valid", 32'(out_valid), 32'd1);
            check("stall.hold_a", out_a, 32'd111);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall.second_a", out_a, 32'd222);
        for (int i = 0; i < 4; i++) begin
            offer(32'h002081B3, 32'h0, 32'(500 + i), 32'd0);
            @(posedge clk); #1;
            check("stream.valid", 32'(out_valid), 32'd1);
            check("stream.a", out_a, 32'(500 + i));
        end

        // Flush drops both the held and the offered instruction
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush.pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        offer(32'h002081B3, 32'h0, 32'd777, 32'd0);
        @(posedge clk); #1;
        check("flush.valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("flush.stays_empty", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset between edges with a valid entry held
        out_ready = 1'b0;
        offer(32'h002081B3, 32'h0, 32'd42, 32'd1);
        @(posedge clk); #1;
        check("arst.pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check_out("arst", mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0));
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        offer(32'h002081B3, 32'h0, 32'd9, 32'd4);
        @(posedge clk); #1;
        check("post_rst.valid", 32'(out_valid), 32'd1);
        check("post_rst.a", out_a, 32'd9);
        in_valid = 1'b0;

        // Random traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = $urandom;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
